// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one registered multiplier between two
// valid/ready requesters and returns each product on a tagged response channel.
module mult_share_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic [2*DATA_WIDTH-1:0] resp_result,
  output logic                    mult_enable,
  output logic [DATA_WIDTH-1:0]   mult_a,
  output logic [DATA_WIDTH-1:0]   mult_b,
  input  logic [2*DATA_WIDTH-1:0] mult_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant0, grant1;

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        // Grants stay low while reset is high so no handshake can slip in.
        if (!reset) begin
          grant0 = req0_valid && (!req1_valid || last_grant);
          grant1 = req1_valid && (!req0_valid || !last_grant);
        end
        if (grant0 || grant1) state_next = BUSY;
      end
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign mult_enable = (state == BUSY);
  assign resp_valid  = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      mult_a      <= '0;
      mult_b      <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            mult_a     <= grant1 ? req1_a : req0_a;
            mult_b     <= grant1 ? req1_b : req0_b;
            resp_id    <= grant1;
            last_grant <= grant1;
            cnt        <= 4'(MULT_LATENCY);
          end
        end
        BUSY: begin
          // cnt reaching zero marks the cycle the multiplier output is valid.
          if (cnt == 4'd0) resp_result <= mult_result;
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: one instance at latency 1 and one at
// latency 3, each in front of a behavioural pipelined multiplier.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_result, mult_result;
  logic        mult_enable;
  logic [31:0] mult_a, mult_b;

  logic        l3_req0_valid, l3_req1_valid, l3_req0_ready, l3_req1_ready;
  logic [31:0] l3_req0_a, l3_req0_b, l3_req1_a, l3_req1_b;
  logic        l3_resp_valid, l3_resp_ready, l3_resp_id;
  logic [63:0] l3_resp_result, l3_mult_result;
  logic        l3_mult_enable;
  logic [31:0] l3_mult_a, l3_mult_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.DATA_WIDTH(32), .MULT_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .mult_enable(mult_enable), .mult_a(mult_a),
    .mult_b(mult_b), .mult_result(mult_result)
  );

  mult_share_arbiter #(.DATA_WIDTH(32), .MULT_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_a(l3_req0_a), .req0_b(l3_req0_b),
    .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_a(l3_req1_a), .req1_b(l3_req1_b),
    .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_id(l3_resp_id),
    .resp_result(l3_resp_result), .mult_enable(l3_mult_enable), .mult_a(l3_mult_a),
    .mult_b(l3_mult_b), .mult_result(l3_mult_result)
  );

  // Multiplier models: one register stage for latency 1, three for latency 3.
  logic [63:0] m1_q;
  logic [63:0] m3_q [3];
  always_ff @(posedge clk) if (mult_enable) m1_q <= 64'(mult_a) * 64'(mult_b);
  always_ff @(posedge clk) begin
    if (l3_mult_enable) begin
      m3_q[0] <= 64'(l3_mult_a) * 64'(l3_mult_b);
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
    end
  end
  assign mult_result    = m1_q;
  assign l3_mult_result = m3_q[2];

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents a request on the latency-1 instance, returns at the negedge after
  // the handshake with valid dropped; waited = -1 if no grant came.
  task automatic send(input logic n, input logic [31:0] a, input logic [31:0] b,
                      output int waited);
    if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    waited = 0;
    #1;
    while (!(n ? req1_ready : req0_ready) && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 50) waited = -1;
    @(negedge clk);
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Called in the cycle after the handshake; lat is cycles from handshake.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!resp_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_result, mult_enable, mult_a, mult_b} !== '0) begin
      bad++;
      $display("FAIL rst_outputs: got v=%b id=%b res=%h en=%b a=%h b=%h want all zero",
               resp_valid, resp_id, resp_result, mult_enable, mult_a, mult_b);
    end
  endtask

  task automatic test_single();
    int en_cnt, first;
    logic id;
    logic [63:0] res;
    en_cnt = 0; first = -1; id = 1'bx; res = 'x;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req0_valid = 1'b0;
        total++; if (mult_a !== 32'd3 || mult_b !== 32'd5) begin bad++; $display("FAIL single_operands: got %h %h want 3 5", mult_a, mult_b); end
      end
      if (mult_enable) en_cnt++;
      if (resp_valid && first < 0) begin first = k; id = resp_id; res = resp_result; end
    end
    total++; if (first !== 3)      begin bad++; $display("FAIL single_latency: got %0d want 3", first); end
    total++; if (en_cnt !== 2)     begin bad++; $display("FAIL single_enable_cycles: got %0d want 2", en_cnt); end
    total++; if (id !== 1'b0)      begin bad++; $display("FAIL single_id: got %b want 0", id); end
    total++; if (res !== 64'd15)   begin bad++; $display("FAIL single_result: got %h want 15", res); end
  endtask

  task automatic test_tie();
    int ngrant, nresp, prev;
    logic [63:0] exp_res;
    ngrant = 0; nresp = 0; prev = -1;
    apply_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd7;          req0_b = 32'd9;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF;  req1_b = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        total++;
        if ({req1_ready, req0_ready} !== (ngrant[0] ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL tie_grant%0d: got r1r0=%b%b want requester %0d", ngrant, req1_ready, req0_ready, ngrant % 2);
        end
        if (prev >= 0) begin
          total++; if (c - prev !== 4) begin bad++; $display("FAIL tie_interval: got %0d want 4", c - prev); end
        end
        prev = c; ngrant++;
      end
      if (resp_valid) begin
        exp_res = nresp[0] ? 64'hFFFF_FFFE_0000_0001 : 64'd63;
        total++; if (resp_id !== nresp[0])   begin bad++; $display("FAIL tie_id%0d: got %b want %b", nresp, resp_id, nresp[0]); end
        total++; if (resp_result !== exp_res) begin bad++; $display("FAIL tie_result%0d: got %h want %h", nresp, resp_result, exp_res); end
        nresp++;
      end
      if (nresp == 4) break;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (nresp !== 4) begin bad++; $display("FAIL tie_count: got %0d want 4", nresp); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int w, lat;
    resp_ready = 1'b0;
    send(1'b1, 32'd6, 32'd7, w);
    wait_resp(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({resp_valid, resp_id, resp_result, req0_ready, req1_ready} !== {1'b1, 1'b1, 64'd42, 2'b00}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b id=%b res=%h r0=%b r1=%b want 1 1 42 0 0",
                        i, resp_valid, resp_id, resp_result, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL bp_no_grant_on_resp: got %b want 0", req0_ready); end
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_next_grant: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(lat);
    total++; if (lat !== 3 || resp_id !== 1'b0 || resp_result !== 64'd6) begin
      bad++; $display("FAIL bp_second: got lat=%0d id=%b res=%h want 3 0 6", lat, resp_id, resp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int seen, w, lat;
    seen = 0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    @(negedge clk);
    req0_valid = 1'b0;
    total++; if (mult_enable !== 1'b1) begin bad++; $display("FAIL mid_busy_enable: got %b want 1", mult_enable); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({resp_valid, mult_enable, mult_a, resp_result} !== '0) begin
      bad++; $display("FAIL mid_busy_cleared: got v=%b en=%b a=%h res=%h want zeros", resp_valid, mult_enable, mult_a, resp_result);
    end
    repeat (10) begin @(negedge clk); if (resp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_busy_no_resp: got %0d want 0", seen); end
    send(1'b1, 32'd2, 32'd2, w);
    wait_resp(lat);
    total++; if (lat !== 3 || resp_id !== 1'b1 || resp_result !== 64'd4) begin
      bad++; $display("FAIL mid_busy_followup: got lat=%0d id=%b res=%h want 3 1 4", lat, resp_id, resp_result);
    end
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_vs_hs_ready: got %b want 0", req0_ready); end
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0;
    total++; if (mult_a !== 32'd0 || mult_enable !== 1'b0) begin
      bad++; $display("FAIL reset_vs_hs_capture: got a=%h en=%b want 0 0", mult_a, mult_enable);
    end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      total++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, resp_result, mult_enable, mult_a, mult_b} !== '0) begin
        bad++; $display("FAIL idle%0d: got r=%b%b v=%b id=%b res=%h en=%b a=%h b=%h want zeros",
                        i, req0_ready, req1_ready, resp_valid, resp_id, resp_result, mult_enable, mult_a, mult_b);
      end
    end
  endtask

  task automatic test_latency_sweep();
    logic        n;
    logic [31:0] a, b;
    logic [63:0] exp_res;
    int          w, lat;
    l3_resp_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n = i[0];
      a = (i < 2) ? 32'hFFFF_FFFF : $urandom;
      b = (i < 2) ? 32'hFFFF_FFFF : $urandom;
      exp_res = 64'(a) * 64'(b);
      if (n) begin l3_req1_valid = 1'b1; l3_req1_a = a; l3_req1_b = b; end
      else   begin l3_req0_valid = 1'b1; l3_req0_a = a; l3_req0_b = b; end
      w = 0; #1;
      while (!(n ? l3_req1_ready : l3_req0_ready) && w < 50) begin @(negedge clk); #1; w++; end
      @(negedge clk);
      l3_req0_valid = 1'b0; l3_req1_valid = 1'b0;
      lat = 1;
      while (!l3_resp_valid && lat < 60) begin @(negedge clk); lat++; end
      total++; if (w >= 50 || lat !== 5) begin bad++; $display("FAIL sweep_latency%0d: got wait=%0d lat=%0d want lat 5", i, w, lat); end
      total++; if (l3_resp_id !== n)          begin bad++; $display("FAIL sweep_id%0d: got %b want %b", i, l3_resp_id, n); end
      total++; if (l3_resp_result !== exp_res) begin bad++; $display("FAIL sweep_result%0d: got %h want %h", i, l3_resp_result, exp_res); end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    l3_req0_valid = 1'b0; l3_req1_valid = 1'b0; l3_resp_ready = 1'b0;
    l3_req0_a = '0; l3_req0_b = '0; l3_req1_a = '0; l3_req1_b = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_reset_mid_busy();
    test_idle();
    test_latency_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
